// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side load/store responder with a big-endian byte array,
//            configurable wait states and valid/ready request and response
//            channels. Define MEM_RESPONDER_ERR_EN for error detection;
//            otherwise accesses wrap and align down.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DEPTH_BYTES = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int         AW     = $clog2(DEPTH_BYTES);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

    logic [7:0]    mem [DEPTH_BYTES];

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          error_q, error_d;

    logic [1:0]    w_in_size;
    logic [AW-1:0] w_in_idx;
    logic          w_in_err;
    logic          w_accept;
    logic          w_cur_write;
    logic [1:0]    w_cur_size;
    logic [AW-1:0] w_cur_idx;
    logic          w_cur_err;
    logic [31:0]   w_rd;

`ifdef MEM_RESPONDER_ERR_EN
    always_comb begin
        w_in_size = req_size;
        w_in_idx  = req_addr[AW-1:0];
        w_in_err  = (req_size == 2'b11)
                  | ((req_size == 2'b01) & req_addr[0])
                  | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                  | (req_addr[31:AW] != '0);
    end
`else
    // Reserved size acts as word; misaligned addresses are aligned down.
    always_comb begin
        w_in_size = (req_size == 2'b11) ? 2'b10 : req_size;
        w_in_idx  = req_addr[AW-1:0];
        if (w_in_size == 2'b01) begin
            w_in_idx[0] = 1'b0;
        end else if (w_in_size == 2'b10) begin
            w_in_idx[1:0] = 2'b00;
        end
        w_in_err  = 1'b0;
    end
`endif

    assign w_accept = (state_q == S_IDLE) & req_valid & ready_q;

    // With zero wait states RESP is entered on the accept edge itself.
    assign w_cur_write = w_accept ? req_write : write_q;
    assign w_cur_size  = w_accept ? w_in_size : size_q;
    assign w_cur_idx   = w_accept ? w_in_idx  : idx_q;
    assign w_cur_err   = w_accept ? w_in_err  : err_q;

    always_comb begin
        w_rd = '0;
        case (w_cur_size)
            2'b00:   w_rd = {24'h0, mem[w_cur_idx]};
            2'b01:   w_rd = {16'h0, mem[w_cur_idx], mem[w_cur_idx | AW'(1)]};
            default: w_rd = {mem[w_cur_idx], mem[w_cur_idx | AW'(1)],
                             mem[w_cur_idx | AW'(2)], mem[w_cur_idx | AW'(3)]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        size_d  = size_q;
        idx_d   = idx_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    write_d = req_write;
                    size_d  = w_in_size;
                    idx_d   = w_in_idx;
                    err_d   = w_in_err;
                    cnt_d   = C_WAIT;
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    error_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_d == S_RESP) && (state_q != S_RESP)) begin
            rdata_d = (w_cur_write | w_cur_err) ? 32'h0 : w_rd;
            error_d = w_cur_err;
        end
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            write_q <= 1'b0;
            size_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            write_q <= write_d;
            size_q  <= size_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Storage is deliberately not reset; stores commit on the accept edge.
    always_ff @(posedge clock) begin
        if (w_accept && req_write && !w_in_err) begin
            case (w_in_size)
                2'b00: mem[w_in_idx] <= req_wdata[7:0];
                2'b01: begin
                    mem[w_in_idx]          <= req_wdata[15:8];
                    mem[w_in_idx | AW'(1)] <= req_wdata[7:0];
                end
                default: begin
                    mem[w_in_idx]          <= req_wdata[31:24];
                    mem[w_in_idx | AW'(1)] <= req_wdata[23:16];
                    mem[w_in_idx | AW'(2)] <= req_wdata[15:8];
                    mem[w_in_idx | AW'(3)] <= req_wdata[7:0];
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

endmodule
`default_nettype wire
